// File: rtl/game_pkg.sv
// Shared types and geometry constants for the shot/target game.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLIGHT    = 2'd1,
    RESOLVE   = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  localparam int COORD_W       = 5;
  localparam int TARGET_Y_BASE = 30;
  localparam int ROW_MAX       = 31;

  // Unsigned column distance taken one bit wider, so columns never wrap.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    if (a >= b) begin
      return {1'b0, a - b};
    end else begin
      return {1'b0, b - a};
    end
  endfunction

endpackage

// File: rtl/shot_judge_if.sv
// Target handshake between the target generator (master) and the shot judge (slave).
interface shot_judge_if;
  import game_pkg::*;

  logic [COORD_W-1:0] target_x;
  logic [COORD_W-1:0] target_y;
  logic               result_valid;
  logic               hit;
  logic               start_new_game;

  modport master (
    output target_x, target_y,
    input  result_valid, hit, start_new_game
  );

  modport slave (
    input  target_x, target_y,
    output result_valid, hit, start_new_game
  );

endinterface

// File: rtl/step_timer.sv
// Prescaler that paces the shot: counts enabled cycles while running and
// flags the last one of each STEP_CYCLES period.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ena_i,
  input  logic clr_i,
  input  logic run_i,
  output logic tc_o
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = run_i & ena_i & (cnt_q == CW'(STEP_CYCLES - 1));

  // Next count: wrap on terminal count or explicit clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, frozen while the global enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ena_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shot_judge.sv
// Flies a player shot up the field toward the latched target and judges hit/miss,
// keeping score and misses and requesting new targets from the generator.
module shot_judge
  import game_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int HIT_TOL     = 1,
  parameter int SCORE_W     = 8,
  parameter int MAX_MISSES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               fire,
  input  logic [COORD_W-1:0] aim_x,
  shot_judge_if.slave        tgt,
  output logic [COORD_W-1:0] shot_x,
  output logic [COORD_W-1:0] shot_y,
  output logic               busy,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         misses,
  output logic               game_over
);

  state_e             state_q;
  logic [COORD_W-1:0] shot_x_q, shot_y_q, tx_q, ty_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         misses_q;
  logic               rv_q, hit_q, sng_q, busy_q, go_q;
  logic               tc_s, launch_s, at_end_s, hit_now_s, last_miss_s;

  assign launch_s    = (state_q == IDLE) & fire & ena;
  assign at_end_s    = (shot_y_q == ty_q) | (shot_y_q == COORD_W'(ROW_MAX));
  assign hit_now_s   = (shot_y_q == ty_q) &
                       (abs_diff(shot_x_q, tx_q) <= (COORD_W + 1)'(HIT_TOL));
  assign last_miss_s = ~hit_now_s & ((misses_q + 3'd1) == 3'(MAX_MISSES));

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .ena_i (ena),
    .clr_i (launch_s),
    .run_i (state_q == FLIGHT),
    .tc_o  (tc_s)
  );

  // Game FSM; the judgement is registered on the edge entering RESOLVE so the
  // pulses and the updated score are visible throughout the RESOLVE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shot_x_q <= '0;
      shot_y_q <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      score_q  <= '0;
      misses_q <= 3'd0;
      rv_q     <= 1'b0;
      hit_q    <= 1'b0;
      sng_q    <= 1'b0;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
    end else if (ena) begin
      rv_q  <= 1'b0;
      sng_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            shot_x_q <= aim_x;
            shot_y_q <= '0;
            tx_q     <= tgt.target_x;
            ty_q     <= tgt.target_y;
            busy_q   <= 1'b1;
            state_q  <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (tc_s && at_end_s) begin
            rv_q    <= 1'b1;
            hit_q   <= hit_now_s;
            sng_q   <= ~last_miss_s;
            state_q <= RESOLVE;
            if (hit_now_s) begin
              score_q <= (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
            end else begin
              misses_q <= misses_q + 3'd1;
            end
          end else if (tc_s) begin
            shot_y_q <= shot_y_q + COORD_W'(1);
          end
        end
        RESOLVE: begin
          // sng_q low here means this was the final miss.
          busy_q  <= 1'b0;
          go_q    <= ~sng_q;
          state_q <= sng_q ? IDLE : GAME_OVER;
        end
        GAME_OVER: begin
          if (fire) begin
            score_q  <= '0;
            misses_q <= 3'd0;
            sng_q    <= 1'b1;
            go_q     <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          go_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tgt.result_valid   = rv_q & ena;
  assign tgt.start_new_game = sng_q & ena;
  assign tgt.hit            = hit_q;
  assign shot_x             = shot_x_q;
  assign shot_y             = shot_y_q;
  assign busy               = busy_q;
  assign score              = score_q;
  assign misses             = misses_q;
  assign game_over          = go_q;

endmodule

// File: tb/tb_shot_judge.sv
// Self-checking bench for shot_judge: directed table, randomized shots against
// a latency/scoring model, reset mid-flight and score saturation.
module tb_shot_judge;

  localparam int STEP = 4;
  localparam int TOL  = 1;
  localparam int MAXM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic       fire = 1'b0;
  logic       fire2 = 1'b0;
  logic [4:0] aim_x = 5'd0;
  logic [4:0] shot_x, shot_y, shot_x2, shot_y2;
  logic       busy, busy2, game_over, game_over2;
  logic [7:0] score;
  logic [1:0] score2;
  logic [2:0] misses, misses2;

  shot_judge_if tif ();
  shot_judge_if tif2 ();

  shot_judge #(.STEP_CYCLES(STEP), .HIT_TOL(TOL), .SCORE_W(8), .MAX_MISSES(MAXM)) u_dut (
    .clk(clk), .reset(reset), .ena(ena), .fire(fire), .aim_x(aim_x), .tgt(tif.slave),
    .shot_x(shot_x), .shot_y(shot_y), .busy(busy), .score(score), .misses(misses),
    .game_over(game_over)
  );

  shot_judge #(.STEP_CYCLES(1), .HIT_TOL(TOL), .SCORE_W(2), .MAX_MISSES(MAXM)) u_sat (
    .clk(clk), .reset(reset), .ena(ena), .fire(fire2), .aim_x(aim_x), .tgt(tif2.slave),
    .shot_x(shot_x2), .shot_y(shot_y2), .busy(busy2), .score(score2), .misses(misses2),
    .game_over(game_over2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_score = 0;
  int m_misses = 0;
  bit m_go = 1'b0;

  typedef struct {
    int aim; int tx; int ty; int gs; int gl; int ehit; int elat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_shot(input int aim, input int tx, input int ty, input int gs,
                         input int gl, input int ehit, input int elat);
    int lat = 0;
    int stray = 0;
    bit got = 1'b0;
    @(negedge clk);
    aim_x = aim[4:0]; tif.target_x = tx[4:0]; tif.target_y = ty[4:0];
    fire = 1'b1; ena = 1'b1;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(negedge clk);
      fire = 1'b0;
      ena = (c >= gs && c < gs + gl) ? 1'b0 : 1'b1;
      if (c == 20) begin
        tif.target_x = 5'($urandom_range(0, 31));
        tif.target_y = 5'(30 + $urandom_range(0, 1));
      end
      #1;
      if (tif.result_valid) begin
        got = 1'b1;
        lat = c;
      end else if (tif.start_new_game) begin
        stray++;
      end
    end
    ena = 1'b1;
    chk("result_seen", int'(got), 1);
    chk("latency", lat, elat);
    chk("pulse_during_flight", stray, 0);
    if (ehit != 0) m_score = (m_score < 255) ? m_score + 1 : 255;
    else m_misses++;
    m_go = (m_misses == MAXM);
    chk("hit", int'(tif.hit), ehit);
    chk("score", int'(score), m_score);
    chk("misses", int'(misses), m_misses);
    chk("start_new_game", int'(tif.start_new_game), int'(!m_go));
    chk("busy_in_resolve", int'(busy), 1);
    chk("shot_x", int'(shot_x), aim);
    chk("shot_y", int'(shot_y), ty);
    @(negedge clk); #1;
    chk("busy_after", int'(busy), 0);
    chk("game_over", int'(game_over), int'(m_go));
    chk("rv_single_pulse", int'(tif.result_valid), 0);
    chk("sng_single_pulse", int'(tif.start_new_game), 0);
  endtask

  task automatic restart();
    @(negedge clk); fire = 1'b1;
    @(negedge clk); fire = 1'b0; #1;
    chk("restart_sng", int'(tif.start_new_game), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_misses", int'(misses), 0);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_no_launch", int'(busy), 0);
    @(negedge clk); #1;
    chk("restart_sng_once", int'(tif.start_new_game), 0);
    m_score = 0; m_misses = 0; m_go = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"}, int'({shot_x, shot_y, busy, score, misses, game_over,
                                 tif.result_valid, tif.hit, tif.start_new_game}), 0);
  endtask

  initial begin
    int aim, tx, ty, gl, gs, d, ehit, cnt, lat;
    bit got;
    tbl[0] = '{10, 10, 30, 0, 0, 1, 125};
    tbl[1] = '{11, 10, 30, 0, 0, 1, 125};
    tbl[2] = '{12, 10, 30, 0, 0, 0, 125};
    tbl[3] = '{31,  0, 30, 0, 0, 0, 125};
    tbl[4] = '{ 5,  5, 31, 0, 0, 1, 129};
    tbl[5] = '{ 3,  4, 30, 30, 7, 1, 132};
    tbl[6] = '{ 0, 20, 31, 0, 0, 0, 129};
    tif.target_x = 5'd0; tif.target_y = 5'd30;
    tif2.target_x = 5'd10; tif2.target_y = 5'd30;

    @(negedge clk); @(negedge clk);
    reset = 1'b0; #1;
    chk_all_zero("reset");

    for (int i = 0; i < 7; i++) begin
      do_shot(tbl[i].aim, tbl[i].tx, tbl[i].ty, tbl[i].gs, tbl[i].gl, tbl[i].ehit, tbl[i].elat);
    end

    for (int i = 0; i < 25; i++) begin
      if (m_go) restart();
      aim = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        tx = aim + int'($urandom_range(0, 4)) - 2;
        if (tx < 0) tx = 0;
        if (tx > 31) tx = 31;
      end else begin
        tx = int'($urandom_range(0, 31));
      end
      ty = int'($urandom_range(30, 31));
      gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
      gs = int'($urandom_range(5, 60));
      d = aim - tx;
      if (d < 0) d = -d;
      ehit = (d <= TOL) ? 1 : 0;
      do_shot(aim, tx, ty, gs, gl, ehit, 1 + (ty + 1) * STEP + gl);
    end

    if (m_go) restart();
    @(negedge clk);
    aim_x = 5'd7; tif.target_x = 5'd7; tif.target_y = 5'd30; fire = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk); fire = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk_all_zero("reset_mid_flight");
    cnt = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk); #1;
      if (tif.result_valid || tif.start_new_game) cnt++;
    end
    chk("no_pulse_after_reset", cnt, 0);

    aim_x = 5'd10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); fire2 = 1'b1;
      got = 1'b0; lat = 0;
      for (int c = 1; c <= 100 && !got; c++) begin
        @(negedge clk); fire2 = 1'b0; #1;
        if (tif2.result_valid) begin
          got = 1'b1;
          lat = c;
        end
      end
      chk("sat_latency", lat, 32);
      chk("sat_hit", int'(tif2.hit), 1);
      chk("sat_score", int'(score2), (k < 3) ? k : 3);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
